// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX sequencer and the register layer.
//   seq_state_t      - sequencer FSM state encoding
//   BYTE_W           - data path width
//   GAP_CYCLES_DEF   - default idle clocks between frames
//   ACK_TIMEOUT_DEF  - default clocks allowed for the UART to acknowledge
//   cnt_w()          - width of a down counter that must hold 0..max_val
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int GAP_CYCLES_DEF  = 16;
    localparam int ACK_TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_CAPTURE  = 3'd2,
        S_LAUNCH   = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_WAIT_END = 3'd5,
        S_GAP      = 3'd6
    } seq_state_t;

    // Never returns 0, so a zero-valued parameter still yields a legal vector.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that saturates at zero.
//   clk, rst   - clock, asynchronous active-low reset
//   load       - load load_val (takes priority over en)
//   en         - decrement by one when non-zero
//   load_val   - value loaded on load
//   zero       - count is zero
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values and simulation matches the synthesized registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_sequencer.sv
// Drains a burst of bytes from the byte-wide ready/data memory into the
// UART transmitter, one fetch per frame, with a programmable idle gap.
//   clk, rst      - clock, asynchronous active-low reset
//   start         - launch a burst (ignored while busy)
//   abort         - level, returns to IDLE at the next edge
//   burst_len     - bytes to send, sampled on an accepted start
//   mem_ready     - one-cycle fetch strobe; mem_data valid the cycle after
//   tx_start      - one-cycle frame launch; tx_data held until frame end
//   tx_busy       - UART busy for the frame duration
//   busy          - high in every state except IDLE
//   done          - one-cycle pulse on normal burst completion
//   err_timeout   - sticky, UART failed to acknowledge tx_start
//   sent_count    - frames completed in the current/last burst
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int LEN_W       = 6,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              mem_ready,
    input  logic [BYTE_W-1:0] mem_data,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [LEN_W-1:0]  sent_count
);

    localparam int GAP_W = cnt_w(GAP_CYCLES);
    localparam int TO_W  = cnt_w(ACK_TIMEOUT);

    // GAP lasts GAP_CYCLES clocks: the final GAP cycle is the one seen at zero.
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // The LAUNCH cycle is the first unacknowledged clock and the last
    // WAIT_ACK cycle is the one seen at zero, so err_timeout appears exactly
    // ACK_TIMEOUT clocks after tx_start (ACK_TIMEOUT >= 2).
    localparam logic [TO_W-1:0] TO_LOAD =
        TO_W'((ACK_TIMEOUT > 2) ? ACK_TIMEOUT - 2 : 0);

    seq_state_t state;

    logic accept;
    logic frame_end;
    logic rem_load, rem_en, rem_zero;
    logic gap_load, gap_en, gap_zero;
    logic to_load, to_en, to_zero;

    assign accept    = (state == S_IDLE) && start && !abort;
    assign frame_end = (state == S_WAIT_END) && !tx_busy && !abort;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rem_load = 1'b0;
        rem_en   = 1'b0;
        gap_load = 1'b0;
        gap_en   = 1'b0;
        to_load  = 1'b0;
        to_en    = 1'b0;
        // remaining holds the bytes still to send after the current one
        rem_load = accept && (burst_len != '0);
        rem_en   = frame_end;
        gap_load = frame_end && !rem_zero && (GAP_CYCLES != 0);
        gap_en   = (state == S_GAP);
        to_load  = (state == S_LAUNCH);
        to_en    = (state == S_WAIT_ACK) && !tx_busy;
    end

    seq_down_counter #(.W(LEN_W)) u_remaining (
        .clk      (clk),
        .rst      (rst),
        .load     (rem_load),
        .en       (rem_en),
        .load_val (burst_len - LEN_W'(1)),
        .zero     (rem_zero)
    );

    seq_down_counter #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .en       (gap_en),
        .load_val (GAP_LOAD),
        .zero     (gap_zero)
    );

    seq_down_counter #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .en       (to_en),
        .load_val (TO_LOAD),
        .zero     (to_zero)
    );

    // Outputs are registered alongside the state so each strobe is high for
    // exactly the cycle spent in its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mem_ready   <= 1'b0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            tx_data     <= '0;
            sent_count  <= '0;
        end else begin
            mem_ready <= 1'b0;
            tx_start  <= 1'b0;
            done      <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            err_timeout <= 1'b0;
                            sent_count  <= '0;
                            if (burst_len != '0) begin
                                state     <= S_FETCH;
                                mem_ready <= 1'b1;
                                busy      <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: state <= S_CAPTURE;
                    S_CAPTURE: begin
                        tx_data  <= mem_data;
                        state    <= S_LAUNCH;
                        tx_start <= 1'b1;
                    end
                    S_LAUNCH: state <= S_WAIT_ACK;
                    S_WAIT_ACK: begin
                        if (tx_busy) begin
                            state <= S_WAIT_END;
                        end else if (to_zero) begin
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                            err_timeout <= 1'b1;
                        end
                    end
                    S_WAIT_END: begin
                        if (!tx_busy) begin
                            sent_count <= sent_count + LEN_W'(1);
                            if (rem_zero) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (GAP_CYCLES == 0) begin
                                state     <= S_FETCH;
                                mem_ready <= 1'b1;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_zero) begin
                            state     <= S_FETCH;
                            mem_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: memory and UART models, a
// launch scoreboard and one task per scenario.
module tb_uart_tx_sequencer;
    import uart_pkg::*;

    localparam int LEN_W = 6;
    localparam int GAP   = 4;
    localparam int ACK   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic              mem_ready;
    logic [BYTE_W-1:0] mem_data = '0;
    logic              tx_start;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_busy = 1'b0;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [LEN_W-1:0]  sent_count;

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .LEN_W       (LEN_W),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .burst_len   (burst_len),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .sent_count  (sent_count)
    );

    // Memory model: data appears the cycle after mem_ready, pointer wraps at 3.
    logic [7:0] mem [3] = '{8'h12, 8'h34, 8'hC1};
    int   mem_ptr    = 0;
    logic mem_rewind = 1'b0;

    always @(posedge clk) begin
        if (mem_rewind) begin
            mem_ptr <= 0;
        end else if (mem_ready) begin
            mem_data <= mem[mem_ptr];
            mem_ptr  <= (mem_ptr == 2) ? 0 : mem_ptr + 1;
        end
    end

    // UART model: busy rises one cycle after tx_start and lasts 10 cycles.
    // uart_mode 1 never acknowledges.
    int uart_mode = 0;
    int busy_left = 0;

    always @(posedge clk) begin
        if (tx_start && uart_mode == 0) begin
            tx_busy   <= 1'b1;
            busy_left <= 9;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];

    int         mem_ready_cnt = 0, tx_start_cnt = 0, done_cnt = 0;
    int         tx_start_cyc = 0, err_rise_cyc = -1, fall_cyc = 0, gap_min = 1000;
    bit         have_fall = 0, prev_busy = 0, prev_err = 0, holding = 0;
    logic [7:0] held = '0;
    logic [7:0] exp_byte;

    // Monitor: scoreboard on tx_start, tx_data hold, fetch ordering, gaps.
    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready_cnt++;
            vectors++;
            if (tx_busy) begin
                miscompares++;
                $display("FAIL fetch_during_frame: tx_busy=%0b at mem_ready, required 0", tx_busy);
            end
            if (have_fall) begin
                if (cyc - fall_cyc < gap_min) gap_min = cyc - fall_cyc;
                have_fall = 0;
            end
        end
        if (tx_start) begin
            tx_start_cnt++;
            tx_start_cyc = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_launch: tx_data=%02h, required no launch", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (tx_data !== exp_byte) begin
                    miscompares++;
                    $display("FAIL launch_data: tx_data=%02h, required %02h", tx_data, exp_byte);
                end
            end
            held    = tx_data;
            holding = 1;
        end else if (holding && tx_busy) begin
            vectors++;
            if (tx_data !== held) begin
                miscompares++;
                $display("FAIL tx_data_hold: tx_data=%02h, required %02h", tx_data, held);
            end
        end
        if (prev_busy && !tx_busy) begin
            fall_cyc  = cyc;
            have_fall = 1;
            holding   = 0;
        end
        if (done) done_cnt++;
        if (err_timeout && !prev_err) err_rise_cyc = cyc;
        prev_busy = tx_busy;
        prev_err  = err_timeout;
    end

    task automatic clear_stats();
        mem_ready_cnt = 0;
        tx_start_cnt  = 0;
        done_cnt      = 0;
        err_rise_cyc  = -1;
        gap_min       = 1000;
        have_fall     = 0;
    endtask

    task automatic rewind();
        @(posedge clk); #1 mem_rewind = 1'b1;
        @(posedge clk); #1 mem_rewind = 1'b0;
    endtask

    // Returns at posedge+1 just after the edge that samples start.
    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start     = 1'b1;
        burst_len = LEN_W'(n);
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({mem_ready, tx_start, busy, done, err_timeout} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: {mem_ready,tx_start,busy,done,err}=%05b, required 00000",
                     {mem_ready, tx_start, busy, done, err_timeout});
        end
        @(posedge clk); #1;
        vectors++;
        if (tx_data !== 8'h00 || sent_count !== '0) begin
            miscompares++;
            $display("FAIL reset_data: tx_data=%02h sent_count=%0d, required 00 and 0", tx_data, sent_count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_burst();
        bit ok;
        clear_stats();
        rewind();
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'hC1);
        pulse_start(3);
        wait_idle(300, ok);
        repeat (3) @(negedge clk);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL burst_complete: busy=%0b after 300 cycles, required 0", busy);
        end
        vectors++;
        if (sent_count !== 6'd3 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL burst_count: sent_count=%0d done_pulses=%0d, required 3 and 1", sent_count, done_cnt);
        end
        vectors++;
        if (mem_ready_cnt !== 3 || tx_start_cnt !== 3 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL burst_strobes: mem_ready=%0d tx_start=%0d left=%0d, required 3 3 0",
                     mem_ready_cnt, tx_start_cnt, exp_q.size());
        end
        vectors++;
        if (gap_min < GAP || gap_min == 1000) begin
            miscompares++;
            $display("FAIL burst_gap: min idle=%0d, required >= %0d", gap_min, GAP);
        end
        vectors++;
        if (tx_data !== 8'hC1 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_idle_hold: tx_data=%02h err=%0b, required C1 and 0", tx_data, err_timeout);
        end
    endtask

    task automatic test_zero_len();
        clear_stats();
        pulse_start(0);
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || sent_count !== '0) begin
            miscompares++;
            $display("FAIL zero_len_done: done=%0b busy=%0b sent=%0d, required 1 0 0", done, busy, sent_count);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (done_cnt !== 1 || mem_ready_cnt !== 0 || tx_start_cnt !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_quiet: done=%0d mem_ready=%0d tx_start=%0d busy=%0b, required 1 0 0 0",
                     done_cnt, mem_ready_cnt, tx_start_cnt, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_stats();
        rewind();
        uart_mode = 1;
        exp_q.push_back(8'h12);
        pulse_start(2);
        wait_idle(ACK + 50, ok);
        repeat (3) @(negedge clk);
        vectors++;
        if (!ok || err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_flag: busy=%0b err=%0b, required 0 and 1", busy, err_timeout);
        end
        vectors++;
        if (err_rise_cyc - tx_start_cyc !== ACK) begin
            miscompares++;
            $display("FAIL timeout_latency: %0d cycles after tx_start, required %0d",
                     err_rise_cyc - tx_start_cyc, ACK);
        end
        vectors++;
        if (done_cnt !== 0 || sent_count !== '0 || mem_ready_cnt !== 1 || tx_start_cnt !== 1) begin
            miscompares++;
            $display("FAIL timeout_side: done=%0d sent=%0d mem_ready=%0d tx_start=%0d, required 0 0 1 1",
                     done_cnt, sent_count, mem_ready_cnt, tx_start_cnt);
        end
        uart_mode = 0;
    endtask

    task automatic test_abort();
        bit ok;
        bit found;
        clear_stats();
        rewind();
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        pulse_start(3);
        vectors++;
        if (err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear_on_start: err=%0b, required 0", err_timeout);
        end
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_start_cnt == 2 && tx_busy) begin
                found = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        vectors++;
        if (!found || busy !== 1'b0 || sent_count !== 6'd1) begin
            miscompares++;
            $display("FAIL abort_idle: reached=%0b busy=%0b sent=%0d, required 1 0 1", found, busy, sent_count);
        end
        // abort together with start in IDLE: start is ignored
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; burst_len = LEN_W'(1);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt !== 0 || busy !== 1'b0 || mem_ready_cnt !== 2) begin
            miscompares++;
            $display("FAIL abort_no_done: done=%0d busy=%0b mem_ready=%0d, required 0 0 2", done_cnt, busy, mem_ready_cnt);
        end
        for (int i = 0; i < 50 && tx_busy; i++) @(negedge clk);
        exp_q.push_back(8'hC1);
        pulse_start(1);
        wait_idle(100, ok);
        repeat (3) @(negedge clk);
        vectors++;
        if (!ok || done_cnt !== 1 || sent_count !== 6'd1 || tx_data !== 8'hC1 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL abort_resume: ok=%0b done=%0d sent=%0d tx_data=%02h left=%0d, required 1 1 1 C1 0",
                     ok, done_cnt, sent_count, tx_data, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_stats();
        rewind();
        uart_mode = 1;
        exp_q.push_back(8'h12);
        pulse_start(2);
        for (int i = 0; i < 50 && tx_start_cnt == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({mem_ready, tx_start, busy, done, err_timeout} !== 5'b0 || tx_data !== 8'h00 || sent_count !== '0) begin
            miscompares++;
            $display("FAIL async_reset: ctrl=%05b tx_data=%02h sent=%0d, required 00000 00 0",
                     {mem_ready, tx_start, busy, done, err_timeout}, tx_data, sent_count);
        end
        @(negedge clk);
        rst = 1'b1;
        uart_mode = 0;
        rewind();
        clear_stats();
        exp_q.push_back(8'h12);
        pulse_start(1);
        wait_idle(100, ok);
        repeat (3) @(negedge clk);
        vectors++;
        if (!ok || done_cnt !== 1 || sent_count !== 6'd1 || err_timeout !== 1'b0 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_recover: ok=%0b done=%0d sent=%0d err=%0b left=%0d, required 1 1 1 0 0",
                     ok, done_cnt, sent_count, err_timeout, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_stats();
        rewind();
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        pulse_start(2);
        repeat (3) @(negedge clk);
        pulse_start(5);
        repeat (20) @(negedge clk);
        pulse_start(3);
        wait_idle(300, ok);
        repeat (6) @(negedge clk);
        vectors++;
        if (!ok || busy !== 1'b0 || sent_count !== 6'd2 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL busy_start_ignored: ok=%0b busy=%0b sent=%0d done=%0d, required 1 0 2 1",
                     ok, busy, sent_count, done_cnt);
        end
        vectors++;
        if (mem_ready_cnt !== 2 || tx_start_cnt !== 2 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL busy_start_strobes: mem_ready=%0d tx_start=%0d left=%0d, required 2 2 0",
                     mem_ready_cnt, tx_start_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_zero_len();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
